param_opcode_pipeline: RTL

//  Generalised N-stage opcode pipeline for the pipelined CPU. Fetches one opcode byte per cycle from
//  the memory data bus into stage 0 and shifts it down the chain; each stage's opcode feeds that

---
 rtl/pipeline_pkg.sv | 14 +
 rtl/pipe_stage_reg.sv | 47 ++++
 rtl/param_opcode_pipeline.sv | 104 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the parametrised opcode pipeline.
package pipeline_pkg;

  // Default bubble opcode. It has to decode as a harmless no-op in every stage ROM.
  localparam logic [7:0] NOP_OP_DEFAULT = 8'h00;

  // What each stage register does on the next edge.
  typedef enum logic [1:0] {
    ADV    = 2'd0,  // take the upstream opcode and valid bit
    HOLD   = 2'd1,  // keep the current contents
    BUBBLE = 2'd2   // load the NOP opcode and clear valid
  } stage_ctrl_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: an opcode register plus its valid bit.
// The upstream data, and whether to advance, hold or bubble, are chosen by the parent.
import pipeline_pkg::*;

module pipe_stage_reg #(
  parameter int               DATA_W = 8,
  parameter logic [DATA_W-1:0] NOP_OP = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  stage_ctrl_e       i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // Stage register. HOLD needs no branch because the flops keep their value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= NOP_OP;
      r_valid <= 1'b0;
    end else begin
      case (i_ctrl)
        ADV: begin
          r_data  <= i_data;
          r_valid <= i_valid;
        end
        BUBBLE: begin
          r_data  <= NOP_OP;
          r_valid <= 1'b0;
        end
        default: begin
          r_data  <= r_data;
          r_valid <= r_valid;
        end
      endcase
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/param_opcode_pipeline.sv
// N-stage opcode fetch pipeline. Opcodes come from the memory bus into stage 0.
// Each stage either advances, holds or takes a bubble. Bus stalls hold the front
// of the pipe and are counted in a saturating stall counter.
import pipeline_pkg::*;

module param_opcode_pipeline #(
  parameter int                NUM_STAGES  = 3,
  parameter int                DATA_W      = 8,
  parameter int                STALL_DEPTH = 2,
  parameter logic [DATA_W-1:0] NOP_OP      = DATA_W'(NOP_OP_DEFAULT),
  parameter int                CNT_W       = 16
) (
  input  logic                         ClockIn,
  input  logic                         Reset,
  input  logic [DATA_W-1:0]            MemData,
  input  logic                         FetchSuppress,
  input  logic                         BusRequest,
  input  logic                         Flush,
  output logic                         IncPC,
  output logic [NUM_STAGES*DATA_W-1:0] StageOpcode,
  output logic [NUM_STAGES-1:0]        StageValid,
  output logic [CNT_W-1:0]             StallCount
);

  logic              w_bus_req;
  logic              w_suppress;
  logic [DATA_W-1:0] w_stage_op [NUM_STAGES];
  logic              w_stage_v  [NUM_STAGES];
  logic [CNT_W-1:0]  r_stall_cnt;

  // The two decode feedback inputs can be X at power-up, before the decode ROMs see
  // defined opcodes. In simulation an X is treated as "not asserted". Synthesis uses the raw pins.
`ifdef SYNTHESIS
  assign w_bus_req  = BusRequest;
  assign w_suppress = FetchSuppress;
`else
  assign w_bus_req  = (BusRequest === 1'b1);
  assign w_suppress = (FetchSuppress === 1'b1);
`endif

  // A byte is consumed only on a plain advance cycle.
  assign IncPC = ~Reset & ~Flush & ~w_bus_req & ~w_suppress;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    stage_ctrl_e       w_ctrl;
    logic [DATA_W-1:0] w_din;
    logic              w_vin;

    // Per-stage control. Priority is flush, then bus stall, then fetch suppress.
    // Reset is handled inside the stage register.
    always_comb begin
      w_ctrl = ADV;
      if (Flush) begin
        w_ctrl = BUBBLE;
      end else if (w_bus_req) begin
        if (k < STALL_DEPTH) begin
          w_ctrl = HOLD;
        end else if (k == STALL_DEPTH) begin
          w_ctrl = BUBBLE;
        end
      end else if (w_suppress && (k == 0)) begin
        w_ctrl = BUBBLE;
      end
    end

    // Stage 0 is fed from the bus. Every other stage is fed from its predecessor.
    if (k == 0) begin : g_head
      assign w_din = MemData;
      assign w_vin = 1'b1;
    end else begin : g_body
      assign w_din = w_stage_op[k-1];
      assign w_vin = w_stage_v[k-1];
    end

    pipe_stage_reg #(
      .DATA_W (DATA_W),
      .NOP_OP (NOP_OP)
    ) u_stage (
      .i_clk   (ClockIn),
      .i_rst   (Reset),
      .i_ctrl  (w_ctrl),
      .i_data  (w_din),
      .i_valid (w_vin),
      .o_data  (w_stage_op[k]),
      .o_valid (w_stage_v[k])
    );

    assign StageOpcode[k*DATA_W +: DATA_W] = w_stage_op[k];
    assign StageValid[k]                   = w_stage_v[k];
  end

  // Stall counter. It counts cycles where BusRequest is actually applied, so a flush
  // cycle is not counted. It stops at all-ones instead of wrapping.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      r_stall_cnt <= '0;
    end else if (!Flush && w_bus_req && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign StallCount = r_stall_cnt;

endmodule
